// File: rtl/cmp_crossing_detector_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cmp_pkg : shared state encoding and l/e/g decode for cmp chain  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LOW  = 2'd0,
    CMP_EQ   = 2'd1,
    CMP_HIGH = 2'd2,
    CMP_INIT = 2'd3
  } cmp_state_t;

  typedef struct packed {
    logic       legal;
    cmp_state_t st;
  } cmp_dec_t;

  // Input ordered {l,e,g}; exactly one-hot codes are meaningful.
  function automatic cmp_dec_t cmp_decode(input logic [2:0] leg);
    cmp_dec_t d;
    d.legal = 1'b1;
    d.st    = CMP_INIT;
    case (leg)
      3'b100:  d.st = CMP_LOW;
      3'b010:  d.st = CMP_EQ;
      3'b001:  d.st = CMP_HIGH;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sat_counter : up-counter that holds at all-ones, clear priority |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] c_MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != c_MAX)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cmp_crossing_detector.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cmp_crossing_detector : hold-filtered threshold crossing pulses |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module cmp_crossing_detector
  import cmp_pkg::*;
#(
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             l,
  input  logic             g,
  input  logic             e,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             rise_p,
  output logic             fall_p,
  output logic             eq_p,
  output logic [CNT_W-1:0] event_count,
  output logic             err
);

  localparam int               RUN_W  = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] c_HOLD = RUN_W'(HOLD);

  cmp_state_t       r_state;
  cmp_state_t       r_cand;   // CMP_INIT doubles as "no candidate"
  logic [RUN_W-1:0] r_run;
  logic             r_rise;
  logic             r_fall;
  logic             r_eq;
  logic             r_err;

  cmp_dec_t         w_dec;
  logic [RUN_W-1:0] w_run_next;
  logic             w_differs;
  logic             w_accept;

  always_comb begin
    w_dec      = cmp_decode({l, e, g});
    w_run_next = (w_dec.st == r_cand) ? (r_run + RUN_W'(1)) : RUN_W'(1);
    w_differs  = in_valid && w_dec.legal && (r_state != CMP_INIT) &&
                 (w_dec.st != r_state);
    w_accept   = w_differs && (w_run_next == c_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CMP_INIT;
      r_cand  <= CMP_INIT;
      r_run   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_eq    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_eq   <= 1'b0;

      if (clear) begin
        r_err <= 1'b0;
      end else if (in_valid && !w_dec.legal) begin
        r_err <= 1'b1;
      end

      if (in_valid) begin
        if (!w_dec.legal) begin
          r_run  <= '0;
          r_cand <= CMP_INIT;
        end else if (r_state == CMP_INIT) begin
          r_state <= w_dec.st;
          r_run   <= '0;
          r_cand  <= CMP_INIT;
        end else if (!w_differs) begin
          r_run <= '0;
        end else if (w_accept) begin
          r_state <= w_dec.st;
          r_run   <= '0;
          r_cand  <= CMP_INIT;
          r_rise  <= (w_dec.st == CMP_HIGH);
          r_fall  <= (w_dec.st == CMP_LOW);
          r_eq    <= (w_dec.st == CMP_EQ);
        end else begin
          r_cand <= w_dec.st;
          r_run  <= w_run_next;
        end
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_event_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_accept),
    .clr   (clear),
    .count (event_count)
  );

  assign state  = r_state;
  assign rise_p = r_rise;
  assign fall_p = r_fall;
  assign eq_p   = r_eq;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmp_crossing_detector.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_cmp_crossing_detector : directed checks, HOLD=3 and HOLD=1   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_cmp_crossing_detector;

  localparam logic [2:0] C_LOW  = 3'b100;
  localparam logic [2:0] C_EQ   = 3'b010;
  localparam logic [2:0] C_HIGH = 3'b001;
  localparam logic [2:0] C_BAD  = 3'b110;
  localparam logic [2:0] C_NONE = 3'b000;

  logic       clk;
  logic       rst_n;

  logic       a_valid, a_l, a_e, a_g, a_clear;
  logic [1:0] a_state;
  logic       a_rise, a_fall, a_eq, a_err;
  logic [7:0] a_cnt;

  logic       b_valid, b_l, b_e, b_g, b_clear;
  logic [1:0] b_state;
  logic       b_rise, b_fall, b_eq, b_err;
  logic [1:0] b_cnt;

  int total;
  int bad;

  cmp_crossing_detector #(.HOLD(3), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid),
    .l(a_l), .g(a_g), .e(a_e), .clear(a_clear),
    .state(a_state), .rise_p(a_rise), .fall_p(a_fall), .eq_p(a_eq),
    .event_count(a_cnt), .err(a_err)
  );

  cmp_crossing_detector #(.HOLD(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid),
    .l(b_l), .g(b_g), .e(b_e), .clear(b_clear),
    .state(b_state), .rise_p(b_rise), .fall_p(b_fall), .eq_p(b_eq),
    .event_count(b_cnt), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample into the selected DUT, then return on the next falling
  // edge so outputs reflect the rising edge that sampled it.
  task automatic tick(input bit sel, input logic v, input logic [2:0] leg, input logic clr);
    if (!sel) begin
      a_valid = v; {a_l, a_e, a_g} = leg; a_clear = clr;
      b_valid = 1'b0; b_clear = 1'b0;
    end else begin
      b_valid = v; {b_l, b_e, b_g} = leg; b_clear = clr;
      a_valid = 1'b0; a_clear = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {a_valid, a_l, a_e, a_g, a_clear} = '0;
    {b_valid, b_l, b_e, b_g, b_clear} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_state_a", 32'(a_state), 32'd3);
    chk("rst_cnt_a",   32'(a_cnt),   32'd0);
    chk("rst_err_a",   32'(a_err),   32'd0);
    chk("rst_pulses_a", 32'({a_rise, a_fall, a_eq}), 32'd0);
    chk("rst_state_b", 32'(b_state), 32'd3);
    chk("rst_cnt_b",   32'(b_cnt),   32'd0);

    // INIT adoption
    tick(0, 1, C_EQ, 0);
    chk("init_state", 32'(a_state), 32'd1);
    chk("init_eq_p",  32'(a_eq),    32'd0);
    chk("init_cnt",   32'(a_cnt),   32'd0);

    // Broken run: H H E H H keeps EQ
    tick(0, 1, C_HIGH, 0);
    tick(0, 1, C_HIGH, 0);
    tick(0, 1, C_EQ,   0);
    tick(0, 1, C_HIGH, 0);
    tick(0, 1, C_HIGH, 0);
    chk("broken_state", 32'(a_state), 32'd1);
    chk("broken_rise",  32'(a_rise),  32'd0);
    tick(0, 1, C_HIGH, 0);
    chk("rise_state", 32'(a_state), 32'd2);
    chk("rise_p",     32'(a_rise),  32'd1);
    chk("rise_eq_p",  32'(a_eq),    32'd0);
    chk("rise_cnt",   32'(a_cnt),   32'd1);
    tick(0, 0, C_NONE, 0);
    chk("rise_p_one_cycle", 32'(a_rise), 32'd0);

    // Idle gaps do not break the run; direct HIGH->LOW
    tick(0, 1, C_LOW,  0);
    tick(0, 0, C_NONE, 0);
    tick(0, 0, C_NONE, 0);
    tick(0, 1, C_LOW,  0);
    chk("gap_state_held", 32'(a_state), 32'd2);
    chk("gap_fall_early", 32'(a_fall),  32'd0);
    tick(0, 1, C_LOW,  0);
    chk("fall_state", 32'(a_state), 32'd0);
    chk("fall_p",     32'(a_fall),  32'd1);
    chk("fall_no_eq", 32'(a_eq),    32'd0);
    chk("fall_no_rise", 32'(a_rise), 32'd0);
    chk("fall_cnt",   32'(a_cnt),   32'd2);
    tick(0, 0, C_NONE, 0);
    chk("fall_p_one_cycle", 32'(a_fall), 32'd0);

    // Illegal code sets err, resets run
    tick(0, 1, C_BAD, 0);
    chk("bad_err",   32'(a_err),   32'd1);
    chk("bad_state", 32'(a_state), 32'd0);
    tick(0, 1, C_HIGH, 0);
    tick(0, 1, C_HIGH, 0);
    tick(0, 1, C_BAD,  0);
    tick(0, 1, C_HIGH, 0);
    tick(0, 1, C_HIGH, 0);
    chk("bad_run_reset", 32'(a_state), 32'd0);
    chk("bad_err_sticky", 32'(a_err),  32'd1);
    tick(0, 0, C_NONE, 1);
    chk("clear_err", 32'(a_err),   32'd0);
    chk("clear_cnt", 32'(a_cnt),   32'd0);
    chk("clear_state", 32'(a_state), 32'd0);
    // Run of 2 survives the clear
    tick(0, 1, C_HIGH, 0);
    chk("post_clear_state", 32'(a_state), 32'd2);
    chk("post_clear_rise",  32'(a_rise),  32'd1);
    chk("post_clear_cnt",   32'(a_cnt),   32'd1);

    // Async reset mid-run
    tick(0, 1, C_LOW, 0);
    tick(0, 1, C_LOW, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(a_state), 32'd3);
    chk("async_cnt",   32'(a_cnt),   32'd0);
    chk("async_err",   32'(a_err),   32'd0);
    a_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("async_idle_state", 32'(a_state), 32'd3);
    tick(0, 1, C_LOW, 0);
    chk("async_adopt_state", 32'(a_state), 32'd0);
    chk("async_adopt_fall",  32'(a_fall),  32'd0);
    chk("async_adopt_cnt",   32'(a_cnt),   32'd0);

    // HOLD=1, CNT_W=2: saturation and clear priority
    tick(1, 1, C_LOW, 0);
    chk("b_adopt_state", 32'(b_state), 32'd0);
    chk("b_adopt_cnt",   32'(b_cnt),   32'd0);
    tick(1, 1, C_HIGH, 0);
    chk("b_t1_rise", 32'(b_rise), 32'd1);
    chk("b_t1_cnt",  32'(b_cnt),  32'd1);
    tick(1, 1, C_LOW,  0);
    chk("b_t2_cnt",  32'(b_cnt),  32'd2);
    tick(1, 1, C_HIGH, 0);
    chk("b_t3_cnt",  32'(b_cnt),  32'd3);
    tick(1, 1, C_LOW,  0);
    tick(1, 1, C_HIGH, 0);
    chk("b_sat_cnt",   32'(b_cnt),   32'd3);
    chk("b_sat_state", 32'(b_state), 32'd2);
    chk("b_sat_rise",  32'(b_rise),  32'd1);
    tick(1, 1, C_LOW, 1);
    chk("b_clr_cnt",   32'(b_cnt),   32'd0);
    chk("b_clr_fall",  32'(b_fall),  32'd1);
    chk("b_clr_state", 32'(b_state), 32'd0);
    tick(1, 0, C_NONE, 0);
    chk("b_fall_one_cycle", 32'(b_fall), 32'd0);
    chk("b_err", 32'(b_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
